univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, register width (>=2).
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(DATA_WIDTH)+1, width of step count.
REQ-003 SHALL have parameter RESET_VAL, default 1 (LSB set, rest 0), register value after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request an operation; sampled only in IDLE.
REQ-007 SHALL have port mode  input  3  operation select: HOLD=0, LOAD=1, SHL=2, SHR=3, ROL=4, ROR=5; codes 6-7 behave as HOLD.
REQ-008 SHALL have port count  input  CNT_WIDTH  number of single-bit steps for shift/rotate modes.
REQ-009 SHALL have port load_data  input  DATA_WIDTH  parallel load value.
REQ-010 SHALL have port ser_in_lsb  input  1  bit entering out[0] on SHL.
REQ-011 SHALL have port ser_in_msb  input  1  bit entering out[DATA_WIDTH-1] on SHR.
REQ-012 SHALL have port out  output  DATA_WIDTH  register contents.
REQ-013 SHALL have port busy  output  1  high while a burst is in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have ports ser_out_msb, ser_out_lsb  output  1 each  combinational copies of out[DATA_WIDTH-1] and out[0].

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 IDLE, start=0: out holds, busy=0, done=0.
REQ-018 IDLE, start=1, mode=LOAD: on that edge out<=load_data, next state DONE.
REQ-019 IDLE, start=1, mode HOLD/invalid, or shift/rotate with count=0: out unchanged, next state DONE.
REQ-020 IDLE, start=1, shift/rotate mode, count>0: latch mode and count, out unchanged, next state SHIFT.
REQ-021 SHIFT: one step per cycle; SHL out<={out[DW-2:0],ser_in_lsb}; SHR out<={ser_in_msb,out[DW-1:1]}; ROL/ROR rotate by one.
REQ-022 Serial inputs SHALL be sampled live at each step edge; mode, count, load_data SHALL be ignored after the start edge.
REQ-023 SHIFT SHALL perform exactly the latched count steps (any value up to 2^CNT_WIDTH-1, including >DATA_WIDTH) and then enter DONE.
REQ-024 busy SHALL be 1 exactly in SHIFT (count cycles); done SHALL be 1 exactly in DONE (one cycle); DONE always returns to IDLE.
REQ-025 start SHALL be ignored in SHIFT and DONE; a new start is accepted on the cycle after done.
REQ-026 Latency: start edge to done high = count+1 edges for shift/rotate with count>0; 1 edge otherwise.

Reset
REQ-027 reset=1 at an edge SHALL force state IDLE, out=RESET_VAL, busy=0, done=0, step counter=0, with priority over all other inputs.
REQ-028 reset during SHIFT SHALL abort the burst; no done pulse for the aborted operation.

Structure
REQ-029 Package univ_shift_pkg SHALL hold mode enum shift_mode_t (3-bit) and FSM enum usr_state_t.
REQ-030 Sub-module shift_step (combinational: current value, mode, serial inputs -> next value) SHALL compute the single-step result.

Verification (DATA_WIDTH=8)
REQ-031 Reset held 2 cycles -> out=8'h01, busy=0, done=0.
REQ-032 start, LOAD, load_data=8'hA5 -> next cycle out=8'hA5, done=1 for one cycle, busy never 1.
REQ-033 From 8'hA5: start, ROL, count=3 -> busy 3 cycles, out=8'h2D, then done one cycle.
REQ-034 From 8'hA5: start, SHR, count=4, ser_in_msb=1 -> out=8'hFA after 4 steps; start pulses during busy ignored.
REQ-035 start, ROR, count=8; reset after 2 steps -> out=8'h01, busy=0, no done.
REQ-036 start, SHL, count=0 -> out unchanged, done one cycle later, busy=0.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: operation codes and
// burst-control FSM states.
package univ_shift_pkg;

    // Operation select. Codes 6 and 7 are unused and act as HOLD.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } usr_state_t;

endpackage

// File: rtl/shift_step.sv
// Single-step combinational shifter: current value, mode, serial inputs
// -> next value. Ports: i_value, i_mode, i_ser_lsb, i_ser_msb -> o_value.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_value,
    input  shift_mode_t           i_mode,
    input  logic                  i_ser_lsb,
    input  logic                  i_ser_msb,
    output logic [DATA_WIDTH-1:0] o_value
);

    always_comb begin
        o_value = i_value;
        unique case (i_mode)
            MODE_SHL: o_value = {i_value[DATA_WIDTH-2:0], i_ser_lsb};
            MODE_SHR: o_value = {i_ser_msb, i_value[DATA_WIDTH-1:1]};
            MODE_ROL: o_value = {i_value[DATA_WIDTH-2:0],
                                 i_value[DATA_WIDTH-1]};
            MODE_ROR: o_value = {i_value[0],
                                 i_value[DATA_WIDTH-1:1]};
            default:  o_value = i_value;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with burst control: load, shift, rotate by N.
// Ports: clk, reset, start, mode, count, load_data, ser_in_* -> out, busy, done, ser_out_*.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL =
        {{(DATA_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ser_in_lsb,
    input  logic                  ser_in_msb,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output logic                  done,
    output logic                  ser_out_msb,
    output logic                  ser_out_lsb
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    usr_state_t            r_state;
    shift_mode_t           r_mode;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_out;

    shift_mode_t           w_mode_in;
    logic                  w_is_shift;
    logic [DATA_WIDTH-1:0] w_step;

    assign w_mode_in  = shift_mode_t'(mode);
    assign w_is_shift = (w_mode_in == MODE_SHL) || (w_mode_in == MODE_SHR) ||
                        (w_mode_in == MODE_ROL) || (w_mode_in == MODE_ROR);

    // Step uses the latched mode; serial inputs are taken live.
    shift_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .i_value   (r_out),
        .i_mode    (r_mode),
        .i_ser_lsb (ser_in_lsb),
        .i_ser_msb (ser_in_msb),
        .o_value   (w_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_HOLD;
            r_count <= '0;
            r_out   <= RESET_VAL;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_mode_in == MODE_LOAD) begin
                            r_out   <= load_data;
                            r_state <= ST_DONE;
                        end else if (w_is_shift && (count != '0)) begin
                            r_mode  <= w_mode_in;
                            r_count <= count;
                            r_state <= ST_SHIFT;
                        end else begin
                            // HOLD, unused codes, or zero-length burst.
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_out   <= w_step;
                    r_count <= r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out         = r_out;
    assign busy        = (r_state == ST_SHIFT);
    assign done        = (r_state == ST_DONE);
    assign ser_out_msb = r_out[DATA_WIDTH-1];
    assign ser_out_lsb = r_out[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (DATA_WIDTH=8).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] mode;
    logic [3:0] count;
    logic [7:0] load_data;
    logic       ser_in_lsb;
    logic       ser_in_msb;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       ser_out_msb;
    logic       ser_out_lsb;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg #(
        .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .count       (count),
        .load_data   (load_data),
        .ser_in_lsb  (ser_in_lsb),
        .ser_in_msb  (ser_in_msb),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        start = 1'b1; mode = 3'd1; load_data = v;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out !== 8'h01 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: out=%h busy=%b done=%b, want 01/0/0",
                     out, busy, done);
        end
        n_checks++;
        if (ser_out_lsb !== 1'b1 || ser_out_msb !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ser_out: lsb=%b msb=%b, want 1/0",
                     ser_out_lsb, ser_out_msb);
        end
    endtask

    task automatic test_load;
        @(negedge clk);
        start = 1'b1; mode = 3'd1; load_data = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (out !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL load: out=%h done=%b busy=%b, want a5/1/0",
                     out, done, busy);
        end
        n_checks++;
        if (ser_out_msb !== 1'b1 || ser_out_lsb !== 1'b1) begin
            n_errors++;
            $display("FAIL load_ser_out: msb=%b lsb=%b, want 1/1",
                     ser_out_msb, ser_out_lsb);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== 8'hA5) begin
            n_errors++;
            $display("FAIL load_after: done=%b busy=%b out=%h, want 0/0/a5",
                     done, busy, out);
        end
    endtask

    task automatic test_rol3;
        int b;
        @(negedge clk);
        start = 1'b1; mode = 3'd4; count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (busy === 1'b1 && b < 40) begin
            b++;
            @(negedge clk);
        end
        n_checks++;
        if (b !== 3) begin
            n_errors++;
            $display("FAIL rol3_busy: busy cycles=%0d, want 3", b);
        end
        n_checks++;
        if (out !== 8'h2D || done !== 1'b1) begin
            n_errors++;
            $display("FAIL rol3_result: out=%h done=%b, want 2d/1",
                     out, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL rol3_done_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_shr_ignore_start;
        int b;
        do_load(8'hA5);
        @(negedge clk);
        start = 1'b1; mode = 3'd3; count = 4'd4; ser_in_msb = 1'b1;
        @(negedge clk);
        b = 0;
        while (busy === 1'b1 && b < 40) begin
            b++;
            // Spurious requests with different mode/count while busy.
            start = b[0];
            mode = 3'd1; count = 4'd1; load_data = 8'h00;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (b !== 4) begin
            n_errors++;
            $display("FAIL shr4_busy: busy cycles=%0d, want 4", b);
        end
        n_checks++;
        if (out !== 8'hFA || done !== 1'b1) begin
            n_errors++;
            $display("FAIL shr4_result: out=%h done=%b, want fa/1",
                     out, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== 8'hFA) begin
            n_errors++;
            $display("FAIL shr4_idle: done=%b busy=%b out=%h, want 0/0/fa",
                     done, busy, out);
        end
        ser_in_msb = 1'b0;
    endtask

    task automatic test_shl_live_serial;
        do_load(8'h81);
        @(negedge clk);
        start = 1'b1; mode = 3'd2; count = 4'd2; ser_in_lsb = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out !== 8'h03 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL shl_step1: out=%h busy=%b, want 03/1", out, busy);
        end
        ser_in_lsb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out !== 8'h06 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL shl_step2: out=%h done=%b, want 06/1", out, done);
        end
        @(negedge clk);
    endtask

    task automatic test_rol_long;
        int b;
        do_load(8'h01);
        @(negedge clk);
        start = 1'b1; mode = 3'd4; count = 4'd9;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (busy === 1'b1 && b < 40) begin
            b++;
            @(negedge clk);
        end
        n_checks++;
        if (b !== 9 || out !== 8'h02 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL rol9: busy=%0d out=%h done=%b, want 9/02/1",
                     b, out, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int seen;
        do_load(8'h3C);
        @(negedge clk);
        start = 1'b1; mode = 3'd5; count = 4'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out !== 8'h1E || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL ror_step1: out=%h busy=%b, want 1e/1", out, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out !== 8'h01 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort: out=%h busy=%b done=%b, want 01/0/0",
                     out, busy, done);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL abort_quiet: busy/done cycles=%0d, want 0", seen);
        end
    endtask

    task automatic test_zero_count;
        @(negedge clk);
        start = 1'b1; mode = 3'd2; count = 4'd0; ser_in_lsb = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (out !== 8'h01 || done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL shl0: out=%h done=%b busy=%b, want 01/1/0",
                     out, done, busy);
        end
        @(negedge clk);
        ser_in_lsb = 1'b0;
    endtask

    task automatic test_invalid_mode;
        @(negedge clk);
        start = 1'b1; mode = 3'd7; count = 4'd5; load_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (out !== 8'h01 || done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mode7: out=%h done=%b busy=%b, want 01/1/0",
                     out, done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (out !== 8'h01 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL mode7_idle: out=%h done=%b, want 01/0",
                     out, done);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 3'd0; count = 4'd0;
        load_data = 8'h00; ser_in_lsb = 1'b0; ser_in_msb = 1'b0;
        test_reset();
        test_load();
        test_rol3();
        test_shr_ignore_start();
        test_shl_live_serial();
        test_rol_long();
        test_reset_abort();
        test_zero_count();
        test_invalid_mode();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
